// File: rtl/dbus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_mem_responder_if
// Brief    : Core-side data-bus request/response bundle for the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
interface dbus_mem_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_mem_responder
// Brief    : Single-outstanding data-bus slave over a byte-strobed word RAM
//            with a fixed address-to-data response latency.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_mem_responder_if.slave  bus
);

  localparam int         c_depth  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_count;
  logic [3:0]            w_next_count;
  logic [31:0]           r_mem [c_depth];
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_is_store;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused_addr;

  // Gating with reset keeps addr_ok low while the block is held in reset
  assign w_accept      = reset && (r_state == S_IDLE) && bus.req_valid;
  assign w_misaligned  = (bus.req_addr[1:0] != 2'b00);
  assign w_is_store    = (bus.req_strobe != 4'b0000);
  assign w_idx         = bus.req_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_WAIT;
            w_next_count = c_lat_m1;
          end
        end
      end
      S_WAIT: begin
        w_next_count = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      if (w_accept) begin
        r_rdata <= (w_misaligned || w_is_store) ? 32'd0 : r_mem[w_idx];
        r_err   <= w_misaligned;
      end
    end
  end

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_accept && !w_misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_strobe[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.req_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.resp_addr_ok = w_accept;
  assign bus.resp_data_ok = (r_state == S_RESP);
  assign bus.resp_data    = (r_state == S_RESP) ? r_rdata : 32'd0;
  assign bus.resp_err     = (r_state == S_RESP) ? r_err : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_mem_responder
// Brief    : Directed self-checking bench for dbus_mem_responder (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        v_valid = 1'b0;
  logic [31:0] v_addr = 32'd0;
  logic [3:0]  v_strobe = 4'd0;
  logic [31:0] v_data = 32'd0;
  int          n_total = 0;
  int          n_pass = 0;

  logic        w_addr_ok;
  logic        w_data_ok;
  logic [31:0] w_rdata;
  logic        w_err;

  dbus_mem_responder_if b2 ();
  dbus_mem_responder_if b1 ();

  assign b2.req_valid  = v_valid & ~sel;
  assign b2.req_addr   = v_addr;
  assign b2.req_strobe = v_strobe;
  assign b2.req_data   = v_data;
  assign b1.req_valid  = v_valid & sel;
  assign b1.req_addr   = v_addr;
  assign b1.req_strobe = v_strobe;
  assign b1.req_data   = v_data;

  assign w_addr_ok = sel ? b1.resp_addr_ok : b2.resp_addr_ok;
  assign w_data_ok = sel ? b1.resp_data_ok : b2.resp_data_ok;
  assign w_rdata   = sel ? b1.resp_data    : b2.resp_data;
  assign w_err     = sel ? b1.resp_err     : b2.resp_err;

  dbus_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b2)
  );

  dbus_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Entered and left just after a rising edge with the selected DUT idle
  task automatic do_req(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic exp_err, input int lat);
    v_valid  = 1'b1;
    v_addr   = addr;
    v_strobe = strb;
    v_data   = data;
    @(negedge clk);
    chk({tag, " addr_ok"}, {31'd0, w_addr_ok}, 32'd1);
    chk({tag, " early data_ok"}, {31'd0, w_data_ok}, 32'd0);
    @(posedge clk);
    #1 v_valid = 1'b0;
    v_data = 32'hFFFF_FFFF;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk({tag, " data_ok"}, {31'd0, w_data_ok}, (k == lat) ? 32'd1 : 32'd0);
      chk({tag, " addr_ok low"}, {31'd0, w_addr_ok}, 32'd0);
      if (k == lat) begin
        chk({tag, " data"}, w_rdata, exp_data);
        chk({tag, " err"}, {31'd0, w_err}, {31'd0, exp_err});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 3 cycles; addr_ok must stay low even with req_valid up
    v_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset addr_ok", {31'd0, w_addr_ok}, 32'd0);
    end
    v_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset addr_ok", {31'd0, w_addr_ok}, 32'd0);
    chk("post-reset data_ok", {31'd0, w_data_ok}, 32'd0);
    chk("post-reset data", w_rdata, 32'd0);
    chk("post-reset err", {31'd0, w_err}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("idle addr_ok", {31'd0, w_addr_ok}, 32'd0);
    end
    @(posedge clk);
    #1;

    do_req("st40",   32'h40, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
    do_req("ld40",   32'h40, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
    do_req("stbyte", 32'h40, 4'b0101, 32'h1122_3344, 32'd0, 1'b0, 2);
    do_req("ldbyte", 32'h40, 4'h0, 32'd0, 32'hDE22_BE44, 1'b0, 2);
    do_req("ldmis",  32'h42, 4'h0, 32'd0, 32'd0, 1'b1, 2);
    do_req("stmis",  32'h41, 4'hF, 32'h0BAD_F00D, 32'd0, 1'b1, 2);
    do_req("ldchk",  32'h40, 4'h0, 32'd0, 32'hDE22_BE44, 1'b0, 2);
    do_req("stalias", 32'h1000, 4'hF, 32'hA5A5_A5A5, 32'd0, 1'b0, 2);
    do_req("ldalias", 32'h0000, 4'h0, 32'd0, 32'hA5A5_A5A5, 1'b0, 2);

    // Continuous req_valid: accepts every LATENCY+1 cycles
    v_valid  = 1'b1;
    v_addr   = 32'h40;
    v_strobe = 4'h0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("held addr_ok", {31'd0, w_addr_ok}, (i % 3 == 0) ? 32'd1 : 32'd0);
      chk("held data_ok", {31'd0, w_data_ok}, (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i % 3 == 2) chk("held data", w_rdata, 32'hDE22_BE44);
      @(posedge clk);
      #1;
    end
    v_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during WAIT aborts the load
    v_valid = 1'b1;
    v_addr  = 32'h40;
    @(negedge clk);
    chk("abort addr_ok", {31'd0, w_addr_ok}, 32'd1);
    @(posedge clk);
    #1 v_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort data_ok", {31'd0, w_data_ok}, 32'd0);
      chk("abort data", w_rdata, 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post-abort data_ok", {31'd0, w_data_ok}, 32'd0);
    end
    @(posedge clk);
    #1;
    do_req("ld after abort", 32'h40, 4'h0, 32'd0, 32'hDE22_BE44, 1'b0, 2);

    // LATENCY=1 instance
    sel = 1'b1;
    do_req("l1 st", 32'h8, 4'hF, 32'h1234_5678, 32'd0, 1'b0, 1);
    do_req("l1 ld", 32'h8, 4'h0, 32'd0, 32'h1234_5678, 1'b0, 1);
    do_req("l1 mis", 32'h9, 4'h0, 32'd0, 32'd0, 1'b1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
